// File: rtl/dma_spi_master_if.sv
// dma_spi_master_if: DMA byte handshake plus SPI pins for the SPI master
interface dma_spi_master_if #(parameter int DIV_W = 4);
  logic             spi_req;
  logic [7:0]       spi_wrdata;
  logic [7:0]       spi_rddata;
  logic             spi_stb;
  logic             spi_start;
  logic [DIV_W-1:0] spi_div;
  logic             spi_busy;
  logic             spi_sck;
  logic             spi_mosi;
  logic             spi_miso;
  modport master (
    output spi_req, spi_wrdata, spi_div, spi_miso,
    input  spi_rddata, spi_stb, spi_start, spi_busy, spi_sck, spi_mosi
  );
  modport slave (
    input  spi_req, spi_wrdata, spi_div, spi_miso,
    output spi_rddata, spi_stb, spi_start, spi_busy, spi_sck, spi_mosi
  );
endinterface

// File: rtl/dma_spi_master.sv
// dma_spi_master: mode-0 SPI byte shifter driven by a DMA level request
module dma_spi_master #(
  parameter int DIV_W = 4
) (
  input logic             clk,
  input logic             reset,
  dma_spi_master_if.slave bus
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state, state_nx;
  logic [7:0]       tx, rx, rd;
  logic [DIV_W-1:0] div_l, cnt;
  logic [2:0]       bits;
  logic             sck, tick, done;
  // half-period expiry and end of the 8th falling edge
  always_comb begin
    tick = cnt == '0;
    done = state == SHIFT && tick && sck && bits == 3'd0;
  end
  // state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  // next state: a request starts a byte, the last falling edge ends it
  always_comb
    state_nx = state == IDLE ? (bus.spi_req ? SHIFT : IDLE) : (done ? IDLE : SHIFT);
  // outputs: accept pulses only in IDLE and never while reset is asserted
  always_comb begin
    bus.spi_stb    = state == IDLE && bus.spi_req && !reset;
    bus.spi_start  = state == IDLE && bus.spi_req && !reset;
    bus.spi_busy   = state == SHIFT;
    bus.spi_mosi   = state == SHIFT ? tx[7] : 1'b1;
    bus.spi_sck    = sck;
    bus.spi_rddata = rd;
  end
  // datapath: divider is latched at accept so later spi_div changes wait for the next byte
  always_ff @(posedge clk) begin
    if (reset) begin
      tx    <= '0;
      rx    <= '0;
      rd    <= 8'hFF;
      div_l <= '0;
      cnt   <= '0;
      bits  <= '0;
      sck   <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.spi_req) begin
        tx    <= bus.spi_wrdata;
        div_l <= bus.spi_div;
        cnt   <= bus.spi_div;
        bits  <= '0;
        sck   <= 1'b0;
      end
    end else if (tick) begin
      cnt <= div_l;
      sck <= ~sck;
      if (!sck) begin
        rx   <= {rx[6:0], bus.spi_miso};
        bits <= bits + 3'd1;
      end else begin
        tx <= {tx[6:0], 1'b0};
        if (bits == 3'd0) rd <= rx;
      end
    end else begin
      cnt <= cnt - 1'b1;
    end
  end
endmodule
